// File: rtl/eq_fir_sequencer.sv
// Frame sequencer for the equalizer FIR bands: sweeps the sample queue oldest-to-newest,
// waits out the filter pipeline, then pulses out_vld; flags samples arriving mid-frame.
module eq_fir_sequencer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TAPS   = 1021,
  parameter int unsigned LAT    = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              new_smpl,
  input  logic              q_full,
  input  logic [ADDR_W-1:0] start_ptr,
  input  logic              ovr_clr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              seq,
  output logic              busy,
  output logic              out_vld,
  output logic              overrun,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned LAT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] tap_cnt, tap_cnt_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_n;
  logic [CNT_W-1:0]  frame_cnt_n;
  logic              seq_n, busy_n, out_vld_n, overrun_n;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tap_cnt   <= '0;
      lat_cnt   <= '0;
      rd_addr   <= '0;
      seq       <= 1'b0;
      busy      <= 1'b0;
      out_vld   <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      tap_cnt   <= tap_cnt_n;
      lat_cnt   <= lat_cnt_n;
      rd_addr   <= rd_addr_n;
      seq       <= seq_n;
      busy      <= busy_n;
      out_vld   <= out_vld_n;
      overrun   <= overrun_n;
      frame_cnt <= frame_cnt_n;
    end
  end

  // Next state and next output values
  always_comb begin
    state_n     = state;
    tap_cnt_n   = tap_cnt;
    lat_cnt_n   = lat_cnt;
    rd_addr_n   = rd_addr;
    frame_cnt_n = frame_cnt;

    case (state)
      IDLE: begin
        if (new_smpl && q_full && en) begin
          state_n   = RUN;
          rd_addr_n = start_ptr;
          tap_cnt_n = '0;
        end
      end
      RUN: begin
        // last tap: address is held so it stays at the newest sample after seq falls
        if (tap_cnt == ADDR_W'(TAPS - 1)) begin
          state_n   = DRAIN;
          lat_cnt_n = '0;
        end else begin
          rd_addr_n = rd_addr + ADDR_W'(1);
          tap_cnt_n = tap_cnt + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (lat_cnt == LAT_W'(LAT - 1)) begin
          state_n     = DONE;
          frame_cnt_n = frame_cnt + CNT_W'(1);
        end else begin
          lat_cnt_n = lat_cnt + LAT_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    seq_n     = (state_n == RUN);
    busy_n    = (state_n != IDLE);
    out_vld_n = (state_n == DONE);

    // a dropped sample outranks a same-cycle clear
    if (new_smpl && busy)
      overrun_n = 1'b1;
    else if (ovr_clr)
      overrun_n = 1'b0;
    else
      overrun_n = overrun;
  end

endmodule

// File: tb/tb_eq_fir_sequencer.sv
// Bench for eq_fir_sequencer: frame scoreboard on the default build, plus a
// cycle-exact sequence on a short TAPS=4 build for back-to-back and overrun timing.
module tb_eq_fir_sequencer;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned TAPS   = 1021;
  localparam int unsigned LAT    = 2;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en, new_smpl, q_full, ovr_clr;
  logic [ADDR_W-1:0] start_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic              seq, busy, out_vld, overrun;
  logic [CNT_W-1:0]  frame_cnt;

  logic              s_en, s_new, s_qf, s_clr;
  logic [ADDR_W-1:0] s_sp;
  logic [ADDR_W-1:0] s_rd_addr;
  logic              s_seq, s_busy, s_vld, s_ovr;
  logic [CNT_W-1:0]  s_fcnt;

  always #5 clk = ~clk;

  eq_fir_sequencer #(.ADDR_W(ADDR_W), .TAPS(TAPS), .LAT(LAT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .en(en), .new_smpl(new_smpl), .q_full(q_full),
    .start_ptr(start_ptr), .ovr_clr(ovr_clr), .rd_addr(rd_addr), .seq(seq),
    .busy(busy), .out_vld(out_vld), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  eq_fir_sequencer #(.ADDR_W(ADDR_W), .TAPS(4), .LAT(2), .CNT_W(CNT_W)) u_small (
    .clk(clk), .rst(rst), .en(s_en), .new_smpl(s_new), .q_full(s_qf),
    .start_ptr(s_sp), .ovr_clr(s_clr), .rd_addr(s_rd_addr), .seq(s_seq),
    .busy(s_busy), .out_vld(s_vld), .overrun(s_ovr), .frame_cnt(s_fcnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: start pointer of each expected frame, popped on out_vld
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] cur_sp;
  int  seq_len, low_cnt;
  bit  in_seq, in_frame, addr_bad;

  always @(negedge clk) begin
    if (rst) begin
      in_seq = 0; in_frame = 0; seq_len = 0; low_cnt = 0; addr_bad = 0;
    end else if (seq) begin
      if (!in_seq) begin
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        cur_sp = (exp_q.size() != 0) ? exp_q[0] : '0;
        in_seq = 1; in_frame = 1; seq_len = 0; low_cnt = 0; addr_bad = 0;
      end
      if (rd_addr !== ADDR_W'(cur_sp + ADDR_W'(seq_len))) addr_bad = 1;
      seq_len++;
    end else begin
      if (in_seq) begin
        chk("seq_len", 32'(seq_len), 32'(TAPS));
        chk("addr_walk", 32'(addr_bad), 32'd0);
        in_seq = 0;
      end
      if (out_vld) begin
        chk("out_vld_expected", 32'(in_frame), 32'd1);
        if (in_frame) begin
          chk("drain_lat", 32'(low_cnt), 32'(LAT));
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          in_frame = 0;
        end
      end else if (in_frame) begin
        low_cnt++;
      end
    end
  end

  task automatic pulse(input logic qf, input logic e, input logic [ADDR_W-1:0] sp);
    @(negedge clk);
    new_smpl = 1'b1; q_full = qf; en = e; start_ptr = sp;
    @(negedge clk);
    new_smpl = 1'b0; q_full = 1'b0; start_ptr = 10'h2AA;
  endtask

  // k counts cycles from the start pulse; returns at the out_vld cycle or budget
  task automatic wait_vld(output int k);
    k = 1;
    while (!out_vld && k < 3000) begin
      @(negedge clk);
      k++;
    end
  endtask

  typedef struct {
    logic              qf;
    logic              e;
    logic [ADDR_W-1:0] sp;
    logic              go;
  } vec_t;

  vec_t tbl[5];
  int   exp_cnt;
  int   k;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{qf: 1'b1, e: 1'b1, sp: 10'h005, go: 1'b1};
    tbl[1] = '{qf: 1'b1, e: 1'b1, sp: 10'h3F0, go: 1'b1};
    tbl[2] = '{qf: 1'b0, e: 1'b1, sp: 10'h100, go: 1'b0};
    tbl[3] = '{qf: 1'b1, e: 1'b0, sp: 10'h100, go: 1'b0};
    tbl[4] = '{qf: 1'b1, e: 1'b1, sp: 10'h3FF, go: 1'b1};

    rst = 1'b1; en = 1'b1; new_smpl = 1'b0; q_full = 1'b0; ovr_clr = 1'b0; start_ptr = '0;
    s_en = 1'b1; s_new = 1'b0; s_qf = 1'b1; s_clr = 1'b0; s_sp = '0;
    exp_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_seq", 32'(seq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // Table: accepted and rejected start requests
    foreach (tbl[i]) begin
      if (tbl[i].go) begin
        exp_q.push_back(tbl[i].sp);
        exp_cnt++;
      end
      pulse(tbl[i].qf, tbl[i].e, tbl[i].sp);
      if (tbl[i].go) begin
        wait_vld(k);
        chk("latency", 32'(k), 32'(1 + TAPS + LAT));
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("rd_addr_hold", 32'(rd_addr), 32'(ADDR_W'(tbl[i].sp + ADDR_W'(TAPS - 1))));
      end else begin
        repeat (4) @(negedge clk);
        chk("rej_seq", 32'(seq), 32'd0);
        chk("rej_busy", 32'(busy), 32'd0);
        chk("rej_overrun", 32'(overrun), 32'd0);
        chk("rej_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      end
      en = 1'b1;
    end

    // Overrun mid-frame, then clear
    exp_q.push_back(10'h200); exp_cnt++;
    pulse(1'b1, 1'b1, 10'h200);
    repeat (299) @(negedge clk);
    pulse(1'b1, 1'b1, 10'h000);
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_vld(k);
    @(negedge clk);
    chk("ovr_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("ovr_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Set and clear together, then en drops mid-frame
    exp_q.push_back(10'h0AB); exp_cnt++;
    pulse(1'b1, 1'b1, 10'h0AB);
    repeat (10) @(negedge clk);
    new_smpl = 1'b1; q_full = 1'b1; ovr_clr = 1'b1;
    @(negedge clk);
    new_smpl = 1'b0; q_full = 1'b0; ovr_clr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    en = 1'b0;
    wait_vld(k);
    chk("en_low_vld", 32'(out_vld), 32'd1);
    @(negedge clk);
    chk("en_low_busy", 32'(busy), 32'd0);
    chk("en_low_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    pulse(1'b1, 1'b0, 10'h111);
    repeat (4) @(negedge clk);
    chk("en_low_noseq", 32'(seq), 32'd0);
    chk("en_low_nobusy", 32'(busy), 32'd0);
    en = 1'b1;
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;

    // Reset mid-frame at tap 500
    exp_q.push_back(10'h010);
    pulse(1'b1, 1'b1, 10'h010);
    repeat (499) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_seq", 32'(seq), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'd0);
    chk("arst_out_vld", 32'(out_vld), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(10'h123); exp_cnt++;
    pulse(1'b1, 1'b1, 10'h123);
    wait_vld(k);
    chk("post_rst_latency", 32'(k), 32'(1 + TAPS + LAT));
    @(negedge clk);
    chk("post_rst_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Short build: overrun on the out_vld cycle, back-to-back start right after
    s_sp = 10'h3FE;
    @(negedge clk);
    s_new = 1'b1;
    @(negedge clk);
    s_new = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      if (j > 1) @(negedge clk);
      if (j == 9) s_new = 1'b0;
      chk("s_seq", 32'(s_seq), 32'((j <= 4) || (j >= 9 && j <= 12)));
      chk("s_out_vld", 32'(s_vld), 32'((j == 7) || (j == 15)));
      if (j <= 4)
        chk("s_rd_addr", 32'(s_rd_addr), 32'(ADDR_W'(10'h3FE + ADDR_W'(j - 1))));
      else if (j >= 9 && j <= 12)
        chk("s_rd_addr", 32'(s_rd_addr), 32'(ADDR_W'(10'h010 + ADDR_W'(j - 9))));
      if (j == 8) begin
        chk("s_ovr_done", 32'(s_ovr), 32'd1);
        chk("s_busy_gap", 32'(s_busy), 32'd0);
      end
      if (j == 7) begin
        s_new = 1'b1;
        s_sp  = 10'h010;
      end
    end
    chk("s_busy_end", 32'(s_busy), 32'd0);
    chk("s_frame_cnt", 32'(s_fcnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
